// File: rtl/glitch_cmd_pkg.sv
// Shared definitions for the glitch command encoder and the command handler:
// command byte constants, FSM state encoding and byte-index helpers.
package glitch_cmd_pkg;

   // Command bytes understood by the glitcher command port
   localparam logic [7:0] CMD_DELAY   = 8'h64;
   localparam logic [7:0] CMD_WIDTH   = 8'h77;
   localparam logic [7:0] CMD_NUM     = 8'h6E;
   localparam logic [7:0] CMD_SPACING = 8'h73;
   localparam logic [7:0] CMD_FIRE    = 8'h74;

   // Byte stream layout: 11 slots, grouped per field plus the trigger
   localparam int NUM_BYTES  = 11;
   localparam int NUM_FIELDS = 4;
   localparam int NUM_GROUPS = 5;

   localparam logic [2:0] GRP_DELAY   = 3'd0;
   localparam logic [2:0] GRP_WIDTH   = 3'd1;
   localparam logic [2:0] GRP_NUM     = 3'd2;
   localparam logic [2:0] GRP_SPACING = 3'd3;
   localparam logic [2:0] GRP_FIRE    = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_NEXT      = 3'd1,
      ST_SEND      = 3'd2,
      ST_WAIT_ACK  = 3'd3,
      ST_WAIT_DONE = 3'd4
   } enc_state_t;

   // Which group a byte slot belongs to
   function automatic logic [2:0] byte_group(input logic [3:0] idx);
      logic [2:0] grp;
      case (idx)
         4'd0, 4'd1, 4'd2: grp = GRP_DELAY;
         4'd3, 4'd4:       grp = GRP_WIDTH;
         4'd5, 4'd6:       grp = GRP_NUM;
         4'd7, 4'd8, 4'd9: grp = GRP_SPACING;
         default:          grp = GRP_FIRE;
      endcase
      return grp;
   endfunction

   // True for the final byte of a field group; completing it commits the shadow
   function automatic logic is_group_last(input logic [3:0] idx);
      return (idx == 4'd2) || (idx == 4'd4) || (idx == 4'd6) || (idx == 4'd9);
   endfunction

endpackage

// File: rtl/glitch_cmd_encoder_uart_tx.sv
// 8N1 UART transmitter, LSB first. Busy rises the cycle after an enable is
// sampled while idle and falls at the end of the stop bit.
module uart_tx #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD_RATE = 115200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data_i,
   input  logic       tx_enable_i,
   output logic       tx_o,
   output logic       tx_busy_o
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic [8:0]       shift_q, shift_d;
   logic             tx_q, tx_d;
   logic             busy_q, busy_d;

   // Frame sequencing: load on enable, advance one bit every CLKS_PER_BIT cycles
   always_comb begin
      baud_cnt_d = baud_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      tx_d       = tx_q;
      busy_d     = busy_q;
      if (!busy_q) begin
         if (tx_enable_i) begin
            // Start bit goes out immediately; shift holds data then stop bit
            shift_d    = {1'b1, tx_data_i};
            tx_d       = 1'b0;
            bit_cnt_d  = 4'd0;
            baud_cnt_d = '0;
            busy_d     = 1'b1;
         end
      end else if (baud_cnt_q == CNT_LAST) begin
         baud_cnt_d = '0;
         if (bit_cnt_q == 4'd9) begin
            busy_d = 1'b0;
            tx_d   = 1'b1;
         end else begin
            tx_d      = shift_q[0];
            shift_d   = {1'b1, shift_q[8:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
         end
      end else begin
         baud_cnt_d = baud_cnt_q + 1'b1;
      end
   end

   // Transmitter state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         baud_cnt_q <= '0;
         bit_cnt_q  <= 4'd0;
         shift_q    <= '1;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
      end
   end

   assign tx_o      = tx_q;
   assign tx_busy_o = busy_q;

endmodule

// File: rtl/glitch_cmd_encoder.sv
// Glitch command encoder: on start, emits the command bytes for every field
// that changed since it was last sent (plus an optional trigger) over UART.
module glitch_cmd_encoder
   import glitch_cmd_pkg::*;
#(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD_RATE = 115200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] delay_i,
   input  logic [7:0]  width_i,
   input  logic [7:0]  num_pulses_i,
   input  logic [15:0] pulse_spacing_i,
   input  logic        fire_i,
   input  logic        start_i,
   output logic        uart_tx_o,
   output logic        busy_o,
   output logic        done_o
);

   enc_state_t state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   // Values latched at start
   logic [15:0] delay_q, delay_d;
   logic [7:0]  width_q, width_d;
   logic [7:0]  num_q, num_d;
   logic [15:0] spacing_q, spacing_d;
   logic        fire_q, fire_d;

   // Shadows of what the glitcher last received
   logic [15:0] sh_delay_q, sh_delay_d;
   logic [7:0]  sh_width_q, sh_width_d;
   logic [7:0]  sh_num_q, sh_num_d;
   logic [15:0] sh_spacing_q, sh_spacing_d;
   logic [NUM_FIELDS-1:0] valid_q, valid_d;

   logic [NUM_FIELDS-1:0] dirty;
   logic [NUM_GROUPS-1:0] group_en;
   logic [NUM_BYTES-1:0]  byte_en;
   logic                  found;
   logic [3:0]            sel_idx;
   logic [7:0]            tx_data;
   logic                  tx_enable;
   logic                  tx_busy;

   assign dirty[GRP_DELAY]   = !valid_q[GRP_DELAY]   || (delay_q   != sh_delay_q);
   assign dirty[GRP_WIDTH]   = !valid_q[GRP_WIDTH]   || (width_q   != sh_width_q);
   assign dirty[GRP_NUM]     = !valid_q[GRP_NUM]     || (num_q     != sh_num_q);
   assign dirty[GRP_SPACING] = !valid_q[GRP_SPACING] || (spacing_q != sh_spacing_q);
   assign group_en = {fire_q, dirty};

   // Per-slot enable: a slot is sent when its group is selected
   for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_byte_en
      assign byte_en[gi] = group_en[byte_group(4'(gi))];
   end

   // Lowest enabled slot at or after the current index
   always_comb begin
      found   = 1'b0;
      sel_idx = 4'd0;
      for (int i = NUM_BYTES - 1; i >= 0; i--) begin
         if (byte_en[i] && (4'(i) >= idx_q)) begin
            found   = 1'b1;
            sel_idx = 4'(i);
         end
      end
   end

   // Byte value for the current slot
   always_comb begin
      tx_data = CMD_FIRE;
      case (idx_q)
         4'd0:    tx_data = CMD_DELAY;
         4'd1:    tx_data = delay_q[15:8];
         4'd2:    tx_data = delay_q[7:0];
         4'd3:    tx_data = CMD_WIDTH;
         4'd4:    tx_data = width_q;
         4'd5:    tx_data = CMD_NUM;
         4'd6:    tx_data = num_q;
         4'd7:    tx_data = CMD_SPACING;
         4'd8:    tx_data = spacing_q[15:8];
         4'd9:    tx_data = spacing_q[7:0];
         default: tx_data = CMD_FIRE;
      endcase
   end

   // Sequencer next-state, latching and shadow commit
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      delay_d      = delay_q;
      width_d      = width_q;
      num_d        = num_q;
      spacing_d    = spacing_q;
      fire_d       = fire_q;
      sh_delay_d   = sh_delay_q;
      sh_width_d   = sh_width_q;
      sh_num_d     = sh_num_q;
      sh_spacing_d = sh_spacing_q;
      valid_d      = valid_q;
      tx_enable    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               delay_d   = delay_i;
               width_d   = width_i;
               num_d     = num_pulses_i;
               spacing_d = pulse_spacing_i;
               fire_d    = fire_i;
               idx_d     = 4'd0;
               busy_d    = 1'b1;
               state_d   = ST_NEXT;
            end
         end
         ST_NEXT: begin
            if (found) begin
               idx_d   = sel_idx;
               state_d = ST_SEND;
            end else begin
               idx_d   = 4'd0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_SEND: begin
            // Single-cycle enable; the next state never re-asserts it
            tx_enable = 1'b1;
            state_d   = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            if (tx_busy) begin
               // Transmitter has taken the byte: commit the group if complete
               if (is_group_last(idx_q)) begin
                  case (byte_group(idx_q))
                     GRP_DELAY: begin
                        sh_delay_d          = delay_q;
                        valid_d[GRP_DELAY]  = 1'b1;
                     end
                     GRP_WIDTH: begin
                        sh_width_d          = width_q;
                        valid_d[GRP_WIDTH]  = 1'b1;
                     end
                     GRP_NUM: begin
                        sh_num_d            = num_q;
                        valid_d[GRP_NUM]    = 1'b1;
                     end
                     GRP_SPACING: begin
                        sh_spacing_d         = spacing_q;
                        valid_d[GRP_SPACING] = 1'b1;
                     end
                     default: ;
                  endcase
               end
               state_d = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            if (!tx_busy) begin
               idx_d   = idx_q + 4'd1;
               state_d = ST_NEXT;
            end
         end
         default: begin
            idx_d   = 4'd0;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Sequencer and shadow registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         idx_q        <= 4'd0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         delay_q      <= 16'd0;
         width_q      <= 8'd0;
         num_q        <= 8'd0;
         spacing_q    <= 16'd0;
         fire_q       <= 1'b0;
         sh_delay_q   <= 16'd0;
         sh_width_q   <= 8'd0;
         sh_num_q     <= 8'd0;
         sh_spacing_q <= 16'd0;
         valid_q      <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         delay_q      <= delay_d;
         width_q      <= width_d;
         num_q        <= num_d;
         spacing_q    <= spacing_d;
         fire_q       <= fire_d;
         sh_delay_q   <= sh_delay_d;
         sh_width_q   <= sh_width_d;
         sh_num_q     <= sh_num_d;
         sh_spacing_q <= sh_spacing_d;
         valid_q      <= valid_d;
      end
   end

   uart_tx #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD_RATE (BAUD_RATE)
   ) u_uart_tx (
      .clk         (clk),
      .rst         (rst),
      .tx_data_i   (tx_data),
      .tx_enable_i (tx_enable),
      .tx_o        (uart_tx_o),
      .tx_busy_o   (tx_busy)
   );

   assign busy_o = busy_q;
   assign done_o = done_q;

endmodule
